// File: rtl/gpio_int_pkg.sv
// Shared types and defaults for the GPIO pin datapath and interrupt engine.
// Edge-select encoding is the software-visible 2-bit field per pin.
package gpio_int_pkg;

    localparam int DEFAULT_WIDTH       = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_t;

    function automatic logic edge_hit(input edge_sel_t sel, input logic rise, input logic fall);
        logic hit;
        hit = 1'b0;
        case (sel)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad-input synchronizer chain plus previous-value register and raw edge flags.
// The previous-value register tracks every cycle so mode/select changes never fake an edge.
module gpio_sync_edge
    import gpio_int_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pad_in_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    always_comb begin
        sync_d[0] = pad_in_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/gpio_int_sel_core.sv
// GPIO pin datapath and interrupt engine: registered pad drive, synchronized read-back,
// per-pin edge-select interrupts with sticky pending bits and a registered irq line.
module gpio_int_sel_core
    import gpio_int_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     mode_i,
    input  logic [WIDTH-1:0]     write_i,
    input  logic [WIDTH-1:0]     pad_in_i,
    output logic [WIDTH-1:0]     pad_out_o,
    output logic [WIDTH-1:0]     pad_oe_o,
    output logic [WIDTH-1:0]     read_o,
    input  logic                 gie_i,
    input  logic [WIDTH-1:0]     ier_i,
    input  logic [2*WIDTH-1:0]   edge_sel_i,
    input  logic [WIDTH-1:0]     ack_i,
    input  logic                 ack_valid_i,
    output logic [WIDTH-1:0]     isr_o,
    output logic                 irq_o
);

    localparam int WARM_MAX = SYNC_STAGES + 1;
    localparam int CNT_W    = $clog2(WARM_MAX + 1);

    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    logic [WIDTH-1:0] pad_out_q, pad_out_d;
    logic [WIDTH-1:0] pad_oe_q,  pad_oe_d;
    logic [WIDTH-1:0] read_q,    read_d;
    logic [WIDTH-1:0] isr_q,     isr_d;
    logic             irq_q,     irq_d;
    logic [CNT_W-1:0] warm_cnt_q, warm_cnt_d;

    logic             warm;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] ack_mask;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clock    (clock),
        .reset    (reset),
        .pad_in_i (pad_in_i),
        .sync_o   (sync_s),
        .rise_o   (rise),
        .fall_o   (fall)
    );

    // Edges are ignored until the synchronizer and previous-value stages hold real pad levels.
    assign warm       = (warm_cnt_q == CNT_W'(WARM_MAX));
    assign warm_cnt_d = warm ? warm_cnt_q : warm_cnt_q + CNT_W'(1);

    always_comb begin
        evt = '0;
        for (int n = 0; n < WIDTH; n++) begin
            evt[n] = edge_hit(edge_sel_t'(edge_sel_i[2*n +: 2]), rise[n], fall[n])
                     & ~mode_i[n] & ier_i[n] & warm;
        end
    end

    // ack_i is only meaningful in the single cycle ack_valid_i is high; a new event wins over it.
    assign ack_mask = ack_valid_i ? ack_i : '0;

    always_comb begin
        pad_oe_d  = mode_i;
        pad_out_d = write_i & mode_i;
        read_d    = sync_s;
        isr_d     = (isr_q & ~ack_mask) | evt;
        irq_d     = gie_i & (|isr_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pad_out_q  <= '0;
            pad_oe_q   <= '0;
            read_q     <= '0;
            isr_q      <= '0;
            irq_q      <= 1'b0;
            warm_cnt_q <= '0;
        end else begin
            pad_out_q  <= pad_out_d;
            pad_oe_q   <= pad_oe_d;
            read_q     <= read_d;
            isr_q      <= isr_d;
            irq_q      <= irq_d;
            warm_cnt_q <= warm_cnt_d;
        end
    end

    assign pad_out_o = pad_out_q;
    assign pad_oe_o  = pad_oe_q;
    assign read_o    = read_q;
    assign isr_o     = isr_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_gpio_int_sel_core.sv
// Bench for gpio_int_sel_core: directed vector table, a reset/warm-up sequence and
// randomized traffic, all checked against a pad-history reference model.
module tb_gpio_int_sel_core;

    localparam int W = 4;
    localparam int S = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic [W-1:0]   mode_i, write_i, pad_in_i, ier_i, ack_i;
    logic [2*W-1:0] edge_sel_i;
    logic           gie_i, ack_valid_i;
    logic [W-1:0]   pad_out_o, pad_oe_o, read_o, isr_o;
    logic           irq_o;

    int tests = 0;
    int fails = 0;

    gpio_int_sel_core #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clock       (clock),
        .reset       (reset),
        .mode_i      (mode_i),
        .write_i     (write_i),
        .pad_in_i    (pad_in_i),
        .pad_out_o   (pad_out_o),
        .pad_oe_o    (pad_oe_o),
        .read_o      (read_o),
        .gie_i       (gie_i),
        .ier_i       (ier_i),
        .edge_sel_i  (edge_sel_i),
        .ack_i       (ack_i),
        .ack_valid_i (ack_valid_i),
        .isr_o       (isr_o),
        .irq_o       (irq_o)
    );

    always #5 clock = ~clock;

    // Reference model: pad samples since reset, newest first; older entries are what the
    // synchronized view and its previous value must currently show.
    logic [W-1:0] hist [$];
    int           edges_since_reset;
    logic [W-1:0] m_oe, m_out, m_read, m_isr;
    logic         m_irq;

    task automatic model_edge();
        logic [W-1:0] s_old, p_old, ack_eff, ev;
        int           sel;
        bit           rise_n, fall_n, hit;
        if (reset) begin
            hist.delete();
            for (int i = 0; i < S + 2; i++) hist.push_back('0);
            edges_since_reset = 0;
            m_oe = '0; m_out = '0; m_read = '0; m_isr = '0; m_irq = 1'b0;
        end else begin
            hist.push_front(pad_in_i);
            s_old = hist[S];
            p_old = hist[S + 1];
            ev = '0;
            for (int n = 0; n < W; n++) begin
                rise_n = (s_old[n] == 1'b1) && (p_old[n] == 1'b0);
                fall_n = (s_old[n] == 1'b0) && (p_old[n] == 1'b1);
                sel    = int'(edge_sel_i[2*n +: 2]);
                hit    = (sel == 1 && rise_n) || (sel == 2 && fall_n) ||
                         (sel == 3 && (rise_n || fall_n));
                if (hit && !mode_i[n] && ier_i[n] && edges_since_reset >= S + 1) ev[n] = 1'b1;
            end
            ack_eff = ack_valid_i ? ack_i : '0;
            m_irq   = gie_i && (m_isr != '0);
            m_isr   = (m_isr & ~ack_eff) | ev;
            m_read  = s_old;
            m_oe    = mode_i;
            m_out   = write_i & mode_i;
            void'(hist.pop_back());
            if (edges_since_reset < 1000) edges_since_reset++;
        end
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("model_oe",   pad_oe_o,  m_oe);
        check("model_out",  pad_out_o, m_out);
        check("model_read", read_o,    m_read);
        check("model_isr",  isr_o,     m_isr);
        check("model_irq",  {3'b0, irq_o}, {3'b0, m_irq});
    endtask

    typedef struct {
        string        name;
        logic         rst;
        logic [W-1:0] mode, wr, pad;
        logic         gie;
        logic [W-1:0] ier;
        logic [7:0]   sel;
        logic [W-1:0] ack;
        logic         ackv;
        int           rep;
        logic [W-1:0] e_oe, e_out, e_read, e_isr;
        logic         e_irq;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(string name, logic rst, logic [3:0] mode, logic [3:0] wr,
                                logic [3:0] pad, logic gie, logic [3:0] ier, logic [7:0] sel,
                                logic [3:0] ack, logic ackv, int rep, logic [3:0] e_oe,
                                logic [3:0] e_out, logic [3:0] e_read, logic [3:0] e_isr,
                                logic e_irq);
        vec_t v;
        v.name = name; v.rst = rst; v.mode = mode; v.wr = wr; v.pad = pad; v.gie = gie;
        v.ier = ier; v.sel = sel; v.ack = ack; v.ackv = ackv; v.rep = rep;
        v.e_oe = e_oe; v.e_out = e_out; v.e_read = e_read; v.e_isr = e_isr; v.e_irq = e_irq;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        reset = v.rst; mode_i = v.mode; write_i = v.wr; pad_in_i = v.pad; gie_i = v.gie;
        ier_i = v.ier; edge_sel_i = v.sel; ack_i = v.ack; ack_valid_i = v.ackv;
    endtask

    initial begin
        reset = 1'b1; mode_i = '0; write_i = '0; pad_in_i = '0; gie_i = 1'b0;
        ier_i = '0; edge_sel_i = '0; ack_i = '0; ack_valid_i = 1'b0;

        //            name             rst mode wr    pad  gie ier  sel    ack ackv rep  oe out  read isr irq
        tbl.push_back(mk("rst_hold",      1, 4'h0, 4'h0, 4'hF, 1, 4'hF, 8'hFF, 4'h0, 0, 2, 4'h0, 4'h0, 4'h0, 4'h0, 0));
        tbl.push_back(mk("warm_pad_high", 0, 4'h0, 4'h0, 4'hF, 1, 4'hF, 8'hFF, 4'h0, 0, 10, 4'h0, 4'h0, 4'hF, 4'h0, 0));
        tbl.push_back(mk("out_path",      0, 4'h3, 4'hA, 4'h3, 1, 4'hF, 8'h55, 4'h0, 0, 1, 4'h3, 4'h2, 4'hF, 4'h0, 0));
        tbl.push_back(mk("fall_ignored",  0, 4'h3, 4'hA, 4'h3, 1, 4'hF, 8'h55, 4'h0, 0, 5, 4'h3, 4'h2, 4'h3, 4'h0, 0));
        tbl.push_back(mk("rise_32",       0, 4'h3, 4'hA, 4'hF, 1, 4'hF, 8'h55, 4'h0, 0, 3, 4'h3, 4'h2, 4'hF, 4'hC, 0));
        tbl.push_back(mk("irq_32",        0, 4'h3, 4'hA, 4'hF, 1, 4'hF, 8'h55, 4'h0, 0, 1, 4'h3, 4'h2, 4'hF, 4'hC, 1));
        tbl.push_back(mk("ack_all",       0, 4'h3, 4'hA, 4'hF, 1, 4'hF, 8'h55, 4'hF, 1, 1, 4'h3, 4'h2, 4'hF, 4'h0, 1));
        tbl.push_back(mk("irq_drop",      0, 4'h3, 4'hA, 4'hF, 1, 4'hF, 8'h55, 4'h0, 0, 1, 4'h3, 4'h2, 4'hF, 4'h0, 0));
        tbl.push_back(mk("pin0_low",      0, 4'h0, 4'hA, 4'hE, 1, 4'h0, 8'h02, 4'h0, 0, 5, 4'h0, 4'h0, 4'hE, 4'h0, 0));
        tbl.push_back(mk("rise_not_sel",  0, 4'h0, 4'hA, 4'hF, 1, 4'h1, 8'h02, 4'h0, 0, 5, 4'h0, 4'h0, 4'hF, 4'h0, 0));
        tbl.push_back(mk("fall_sel",      0, 4'h0, 4'hA, 4'hE, 1, 4'h1, 8'h02, 4'h0, 0, 3, 4'h0, 4'h0, 4'hE, 4'h1, 0));
        tbl.push_back(mk("fall_irq",      0, 4'h0, 4'hA, 4'hE, 1, 4'h1, 8'h02, 4'h0, 0, 1, 4'h0, 4'h0, 4'hE, 4'h1, 1));
        tbl.push_back(mk("both_prep",     0, 4'h0, 4'hA, 4'hF, 1, 4'h1, 8'h03, 4'h0, 0, 2, 4'h0, 4'h0, 4'hE, 4'h1, 1));
        tbl.push_back(mk("set_beats_ack", 0, 4'h0, 4'hA, 4'hF, 1, 4'h1, 8'h03, 4'h1, 1, 1, 4'h0, 4'h0, 4'hF, 4'h1, 1));
        tbl.push_back(mk("ack_unstrobed", 0, 4'h0, 4'hA, 4'hF, 1, 4'h1, 8'h03, 4'h1, 0, 3, 4'h0, 4'h0, 4'hF, 4'h1, 1));
        tbl.push_back(mk("ack_clear",     0, 4'h0, 4'hA, 4'hF, 1, 4'h1, 8'h03, 4'h1, 1, 1, 4'h0, 4'h0, 4'hF, 4'h0, 1));
        tbl.push_back(mk("irq_fall",      0, 4'h0, 4'hA, 4'hF, 1, 4'h1, 8'h03, 4'h0, 0, 1, 4'h0, 4'h0, 4'hF, 4'h0, 0));
        tbl.push_back(mk("pin2_low",      0, 4'h0, 4'hA, 4'hB, 0, 4'h4, 8'h10, 4'h0, 0, 4, 4'h0, 4'h0, 4'hB, 4'h0, 0));
        tbl.push_back(mk("gie_mask",      0, 4'h0, 4'hA, 4'hF, 0, 4'h4, 8'h10, 4'h0, 0, 3, 4'h0, 4'h0, 4'hF, 4'h4, 0));
        tbl.push_back(mk("isr_hold",      0, 4'h0, 4'hA, 4'hF, 0, 4'h4, 8'h10, 4'h0, 0, 2, 4'h0, 4'h0, 4'hF, 4'h4, 0));
        tbl.push_back(mk("gie_on",        0, 4'h0, 4'hA, 4'hF, 1, 4'h4, 8'h10, 4'h0, 0, 1, 4'h0, 4'h0, 4'hF, 4'h4, 1));
        tbl.push_back(mk("ier_clr_keeps", 0, 4'h0, 4'hA, 4'hF, 1, 4'h0, 8'h10, 4'h0, 0, 2, 4'h0, 4'h0, 4'hF, 4'h4, 1));
        tbl.push_back(mk("all_fall",      0, 4'h0, 4'hA, 4'h0, 1, 4'hF, 8'hFF, 4'h0, 0, 3, 4'h0, 4'h0, 4'h0, 4'hF, 1));
        tbl.push_back(mk("mid_reset",     1, 4'h0, 4'hA, 4'h0, 1, 4'hF, 8'hFF, 4'hF, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            for (int r = 0; r < tbl[i].rep; r++) step();
            check({tbl[i].name, "_oe"},   pad_oe_o,  tbl[i].e_oe);
            check({tbl[i].name, "_out"},  pad_out_o, tbl[i].e_out);
            check({tbl[i].name, "_read"}, read_o,    tbl[i].e_read);
            check({tbl[i].name, "_isr"},  isr_o,     tbl[i].e_isr);
            check({tbl[i].name, "_irq"},  {3'b0, irq_o}, {3'b0, tbl[i].e_irq});
        end

        // Pads toggle every cycle right after reset: nothing may latch until the 4th edge.
        reset = 1'b0; ack_valid_i = 1'b0; ack_i = '0;
        for (int j = 1; j <= 4; j++) begin
            pad_in_i = (j % 2 == 1) ? 4'hF : 4'h0;
            step();
            check($sformatf("warmup_isr_e%0d", j), isr_o, (j < 4) ? 4'h0 : 4'hF);
        end
        step();
        check("warmup_irq", {3'b0, irq_o}, 4'h1);

        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            mode_i      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            write_i     = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) pad_in_i = 4'($urandom_range(0, 15));
            gie_i       = ($urandom_range(0, 7) != 0);
            ier_i       = 4'($urandom_range(0, 15));
            edge_sel_i  = 8'($urandom_range(0, 255));
            ack_valid_i = ($urandom_range(0, 3) == 0);
            ack_i       = 4'($urandom_range(0, 15));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
